// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (IF) and load/store (LS).
// LS wins ties; a saturating starvation count forces IF through after STARVE_MAX LS wins.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_gnt,
  output logic                o_if_rvalid,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_ls_req,
  input  logic                i_ls_wen,
  input  logic [ADDR_W-1:0]   i_ls_addr,
  input  logic [DATA_W-1:0]   i_ls_wdata,
  input  logic [DATA_W/8-1:0] i_ls_mask,
  output logic                o_ls_gnt,
  output logic                o_ls_rvalid,
  output logic [DATA_W-1:0]   o_ls_rdata,
  output logic                o_mem_req,
  output logic                o_mem_wen,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_mask,
  input  logic                i_mem_ready,
  input  logic                i_mem_rvalid,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_busy,
  output logic                o_err
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] starve_sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt >= STARVE_LIM) begin
      return STARVE_LIM;
    end
    return cnt + 1'b1;
  endfunction

  state_t             state_q;
  state_t             state_d;
  logic               owner_ls_p0;
  logic               owner_ls_d;
  logic [CNT_W-1:0]   starve_q;
  logic [CNT_W-1:0]   starve_d;
  logic               gnt_if;
  logic               gnt_ls;
  logic               issue_accept;
  logic               resp_take;
  logic               err_q;

  logic               cap_wen_p0;
  logic [ADDR_W-1:0]  cap_addr_p0;
  logic [DATA_W-1:0]  cap_wdata_p0;
  logic [MASK_W-1:0]  cap_mask_p0;

  logic               if_rvalid_p1;
  logic [DATA_W-1:0]  if_rdata_p1;
  logic               ls_rvalid_p1;
  logic [DATA_W-1:0]  ls_rdata_p1;

  assign issue_accept = (state_q == ISSUE) && i_mem_ready;
  assign resp_take    = (state_q == WAIT_RESP) && i_mem_rvalid;

  // Arbitration and next-state: decision made combinationally while IDLE
  always_comb begin
    state_d    = state_q;
    owner_ls_d = owner_ls_p0;
    starve_d   = starve_q;
    gnt_if     = 1'b0;
    gnt_ls     = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_ls_req && (!i_if_req || (starve_q != STARVE_LIM))) begin
          gnt_ls = 1'b1;
        end else if (i_if_req) begin
          gnt_if = 1'b1;
        end
        if (gnt_ls) begin
          state_d    = ISSUE;
          owner_ls_d = 1'b1;
        end else if (gnt_if) begin
          state_d    = ISSUE;
          owner_ls_d = 1'b0;
        end
        if (!i_if_req || gnt_if) begin
          starve_d = '0;
        end else if (gnt_ls) begin
          starve_d = starve_sat_inc(starve_q);
        end
      end
      ISSUE: begin
        if (i_mem_ready) begin
          state_d = cap_wen_p0 ? IDLE : WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (i_mem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= IDLE;
      owner_ls_p0 <= 1'b0;
      starve_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_ls_p0 <= owner_ls_d;
      starve_q    <= starve_d;
      if (i_mem_rvalid && (state_q != WAIT_RESP)) begin
        err_q <= 1'b1;
      end
    end
  end

  // Capture stage: request fields latched on the granting edge
  always_ff @(posedge clk) begin
    if (gnt_ls) begin
      cap_wen_p0   <= i_ls_wen;
      cap_addr_p0  <= i_ls_addr;
      cap_wdata_p0 <= i_ls_wdata;
      cap_mask_p0  <= i_ls_mask;
    end else if (gnt_if) begin
      cap_wen_p0   <= 1'b0;
      cap_addr_p0  <= i_if_addr;
      cap_wdata_p0 <= '0;
      cap_mask_p0  <= '1;
    end
  end

  // Response stage: completion routed to the owner one cycle later
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      if_rvalid_p1 <= 1'b0;
      ls_rvalid_p1 <= 1'b0;
      if_rdata_p1  <= '0;
      ls_rdata_p1  <= '0;
    end else begin
      if_rvalid_p1 <= resp_take && !owner_ls_p0;
      ls_rvalid_p1 <= (resp_take && owner_ls_p0) || (issue_accept && cap_wen_p0);
      if (resp_take && !owner_ls_p0) begin
        if_rdata_p1 <= i_mem_rdata;
      end
      if (resp_take && owner_ls_p0) begin
        ls_rdata_p1 <= i_mem_rdata;
      end else if (issue_accept && cap_wen_p0) begin
        ls_rdata_p1 <= '0;
      end
    end
  end

  // Grants are suppressed while reset is asserted so nothing is handed out mid-reset
  assign o_if_gnt    = gnt_if && i_rst;
  assign o_ls_gnt    = gnt_ls && i_rst;
  assign o_if_rvalid = if_rvalid_p1;
  assign o_if_rdata  = if_rdata_p1;
  assign o_ls_rvalid = ls_rvalid_p1;
  assign o_ls_rdata  = ls_rdata_p1;

  assign o_mem_req   = (state_q == ISSUE);
  assign o_mem_wen   = o_mem_req && cap_wen_p0;
  assign o_mem_addr  = o_mem_req ? cap_addr_p0  : '0;
  assign o_mem_wdata = o_mem_req ? cap_wdata_p0 : '0;
  assign o_mem_mask  = o_mem_req ? cap_mask_p0  : '0;

  assign o_busy = (state_q != IDLE);
  assign o_err  = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic scored
// against a transaction-level model of grant order, memory requests and responses.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt;
  logic        o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        i_ls_req;
  logic        i_ls_wen;
  logic [31:0] i_ls_addr;
  logic [31:0] i_ls_wdata;
  logic [3:0]  i_ls_mask;
  logic        o_ls_gnt;
  logic        o_ls_rvalid;
  logic [31:0] o_ls_rdata;
  logic        o_mem_req;
  logic        o_mem_wen;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        i_mem_ready;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_busy;
  logic        o_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .i_rst(i_rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_ls_req(i_ls_req), .i_ls_wen(i_ls_wen), .i_ls_addr(i_ls_addr),
    .i_ls_wdata(i_ls_wdata), .i_ls_mask(i_ls_mask), .o_ls_gnt(o_ls_gnt),
    .o_ls_rvalid(o_ls_rvalid), .o_ls_rdata(o_ls_rdata),
    .o_mem_req(o_mem_req), .o_mem_wen(o_mem_wen), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
    .i_mem_ready(i_mem_ready), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_busy(o_busy), .o_err(o_err)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // transaction-level reference state
  int          m_phase;
  int          m_starve;
  logic        m_owner_ls;
  logic        m_wen;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_mask;
  logic        exp_rv_if;
  logic        exp_rv_ls;
  logic [31:0] exp_rd_if;
  logic [31:0] exp_rd_ls;
  logic        rd_pend;
  int          rd_delay;
  logic [31:0] rd_data;
  logic        if_done;
  logic        ls_done;
  int          grant_log[$];
  logic        t5_seen;
  logic        t5_ls_gnt;
  int          exp_order[6] = '{1, 1, 1, 1, 0, 1};

  task automatic drive_idle();
    i_if_req     = 1'b0;
    i_if_addr    = '0;
    i_ls_req     = 1'b0;
    i_ls_wen     = 1'b0;
    i_ls_addr    = '0;
    i_ls_wdata   = '0;
    i_ls_mask    = '0;
    i_mem_ready  = 1'b0;
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = '0;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_rst = 1'b1;
  endtask

  task automatic run_cycles(input int n, input bit held);
    logic        e_gl;
    logic        e_gi;
    logic        n_rv_if;
    logic        n_rv_ls;
    logic [31:0] n_rd_if;
    logic [31:0] n_rd_ls;
    m_phase   = 0;
    m_starve  = 0;
    exp_rv_if = 1'b0;
    exp_rv_ls = 1'b0;
    rd_pend   = 1'b0;
    if_done   = 1'b0;
    ls_done   = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = $urandom;
      if (rd_pend) begin
        if (rd_delay == 0) begin
          i_mem_rvalid = 1'b1;
          i_mem_rdata  = rd_data;
          rd_pend      = 1'b0;
        end else begin
          rd_delay--;
        end
      end
      i_mem_ready = held ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (if_done) i_if_req = 1'b0;
      else if (!held && i_if_req && ($urandom_range(0, 9) == 0)) i_if_req = 1'b0;
      if (!i_if_req && (held || ($urandom_range(0, 2) == 0))) begin
        i_if_req  = 1'b1;
        i_if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (ls_done) i_ls_req = 1'b0;
      else if (!held && i_ls_req && ($urandom_range(0, 9) == 0)) i_ls_req = 1'b0;
      if (!i_ls_req && (held || ($urandom_range(0, 1) == 0))) begin
        i_ls_req   = 1'b1;
        i_ls_wen   = held ? 1'b0 : ($urandom_range(0, 1) == 1);
        i_ls_addr  = $urandom;
        i_ls_wdata = $urandom;
        i_ls_mask  = 4'($urandom);
      end
      @(negedge clk);
      e_gl = (m_phase == 0) && i_ls_req && (!i_if_req || (m_starve != STARVE_MAX));
      e_gi = (m_phase == 0) && i_if_req && !e_gl;
      chk("if_gnt", 64'(o_if_gnt), 64'(e_gi));
      chk("ls_gnt", 64'(o_ls_gnt), 64'(e_gl));
      chk("busy", 64'(o_busy), 64'(m_phase != 0));
      chk("mem_req", 64'(o_mem_req), 64'(m_phase == 1));
      if (m_phase == 1) begin
        chk("mem_addr", 64'(o_mem_addr), 64'(m_addr));
        chk("mem_wen", 64'(o_mem_wen), 64'(m_wen));
        chk("mem_mask", 64'(o_mem_mask), 64'(m_mask));
        if (m_wen) chk("mem_wdata", 64'(o_mem_wdata), 64'(m_wdata));
      end
      chk("if_rvalid", 64'(o_if_rvalid), 64'(exp_rv_if));
      chk("ls_rvalid", 64'(o_ls_rvalid), 64'(exp_rv_ls));
      if (exp_rv_if) chk("if_rdata", 64'(o_if_rdata), 64'(exp_rd_if));
      if (exp_rv_ls) chk("ls_rdata", 64'(o_ls_rdata), 64'(exp_rd_ls));
      chk("err_clear", 64'(o_err), 64'(0));
      if (e_gl) grant_log.push_back(1);
      else if (e_gi) grant_log.push_back(0);
      if (held && exp_rv_if && !t5_seen) begin
        t5_seen   = 1'b1;
        t5_ls_gnt = o_ls_gnt;
      end
      n_rv_if = 1'b0;
      n_rv_ls = 1'b0;
      n_rd_if = exp_rd_if;
      n_rd_ls = exp_rd_ls;
      case (m_phase)
        0: begin
          if (!i_if_req || e_gi) m_starve = 0;
          else if (e_gl) m_starve = (m_starve >= STARVE_MAX) ? STARVE_MAX : m_starve + 1;
          if (e_gl) begin
            m_phase = 1; m_owner_ls = 1'b1; m_wen = i_ls_wen;
            m_addr = i_ls_addr; m_wdata = i_ls_wdata; m_mask = i_ls_mask;
          end else if (e_gi) begin
            m_phase = 1; m_owner_ls = 1'b0; m_wen = 1'b0;
            m_addr = i_if_addr; m_wdata = '0; m_mask = 4'hF;
          end
        end
        1: begin
          if (i_mem_ready) begin
            if (m_wen) begin
              m_phase = 0; n_rv_ls = 1'b1; n_rd_ls = '0;
            end else begin
              m_phase  = 2;
              rd_pend  = 1'b1;
              rd_delay = held ? 0 : int'($urandom_range(0, 3));
              rd_data  = $urandom;
            end
          end
        end
        2: begin
          if (i_mem_rvalid) begin
            m_phase = 0;
            if (m_owner_ls) begin n_rv_ls = 1'b1; n_rd_ls = i_mem_rdata; end
            else begin n_rv_if = 1'b1; n_rd_if = i_mem_rdata; end
          end
        end
        default: ;
      endcase
      exp_rv_if = n_rv_if;
      exp_rv_ls = n_rv_ls;
      exp_rd_if = n_rd_if;
      exp_rd_ls = n_rd_ls;
      if_done   = e_gi;
      ls_done   = e_gl;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst = 1'b1;
    drive_idle();
    #3;
    i_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(o_busy), 64'(0));
    chk("rst_mem_req", 64'(o_mem_req), 64'(0));
    chk("rst_mem_addr", 64'(o_mem_addr), 64'(0));
    chk("rst_err", 64'(o_err), 64'(0));
    chk("rst_if_rvalid", 64'(o_if_rvalid), 64'(0));
    chk("rst_ls_rvalid", 64'(o_ls_rvalid), 64'(0));
    chk("rst_if_rdata", 64'(o_if_rdata), 64'(0));
    @(negedge clk);
    i_rst = 1'b1;

    // IF read with immediate ready and next-cycle response
    @(posedge clk); #1;
    i_if_req = 1'b1; i_if_addr = 32'h100; i_mem_ready = 1'b1;
    @(negedge clk);
    chk("t2_if_gnt", 64'(o_if_gnt), 64'(1));
    chk("t2_ls_gnt", 64'(o_ls_gnt), 64'(0));
    chk("t2_req_t0", 64'(o_mem_req), 64'(0));
    @(posedge clk); #1;
    i_if_req = 1'b0;
    @(negedge clk);
    chk("t2_req_t1", 64'(o_mem_req), 64'(1));
    chk("t2_addr", 64'(o_mem_addr), 64'(32'h100));
    chk("t2_wen", 64'(o_mem_wen), 64'(0));
    chk("t2_mask", 64'(o_mem_mask), 64'(4'hF));
    @(posedge clk); #1;
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0050_0093;
    @(negedge clk);
    chk("t2_rv_t2", 64'(o_if_rvalid), 64'(0));
    chk("t2_req_t2", 64'(o_mem_req), 64'(0));
    @(posedge clk); #1;
    i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    @(negedge clk);
    chk("t2_if_rvalid", 64'(o_if_rvalid), 64'(1));
    chk("t2_if_rdata", 64'(o_if_rdata), 64'(32'h0050_0093));
    chk("t2_ls_rvalid", 64'(o_ls_rvalid), 64'(0));
    chk("t2_busy_t3", 64'(o_busy), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_rv_pulse", 64'(o_if_rvalid), 64'(0));

    // LS store held off by memory for three cycles
    @(posedge clk); #1;
    i_ls_req = 1'b1; i_ls_wen = 1'b1; i_ls_addr = 32'h2000;
    i_ls_wdata = 32'hDEAD_BEEF; i_ls_mask = 4'b0011; i_mem_ready = 1'b0;
    @(negedge clk);
    chk("t3_ls_gnt", 64'(o_ls_gnt), 64'(1));
    chk("t3_if_gnt", 64'(o_if_gnt), 64'(0));
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      i_ls_req = 1'b0; i_ls_addr = '0; i_ls_wdata = '0; i_ls_mask = '0;
      i_mem_ready = (k == 3);
      @(negedge clk);
      chk($sformatf("t3_req%0d", k), 64'(o_mem_req), 64'(1));
      chk($sformatf("t3_wen%0d", k), 64'(o_mem_wen), 64'(1));
      chk($sformatf("t3_addr%0d", k), 64'(o_mem_addr), 64'(32'h2000));
      chk($sformatf("t3_wdata%0d", k), 64'(o_mem_wdata), 64'(32'hDEAD_BEEF));
      chk($sformatf("t3_mask%0d", k), 64'(o_mem_mask), 64'(4'b0011));
      chk($sformatf("t3_rv%0d", k), 64'(o_ls_rvalid), 64'(0));
    end
    @(posedge clk); #1;
    i_mem_ready = 1'b0;
    @(negedge clk);
    chk("t3_ls_rvalid", 64'(o_ls_rvalid), 64'(1));
    chk("t3_ls_rdata", 64'(o_ls_rdata), 64'(0));
    chk("t3_busy", 64'(o_busy), 64'(0));
    chk("t3_if_rvalid", 64'(o_if_rvalid), 64'(0));

    // Reset while a read is outstanding
    @(posedge clk); #1;
    i_if_req = 1'b1; i_if_addr = 32'h300; i_mem_ready = 1'b1;
    @(negedge clk);
    chk("t1_if_gnt", 64'(o_if_gnt), 64'(1));
    @(posedge clk); #1;
    i_if_req = 1'b0;
    @(posedge clk); #1;
    i_mem_ready = 1'b0;
    @(negedge clk);
    chk("t1_busy_pre", 64'(o_busy), 64'(1));
    #1;
    i_if_req = 1'b1; i_ls_req = 1'b1; i_ls_wen = 1'b0;
    i_rst = 1'b0;
    #1;
    chk("t1_busy", 64'(o_busy), 64'(0));
    chk("t1_mem_req", 64'(o_mem_req), 64'(0));
    chk("t1_if_gnt_rst", 64'(o_if_gnt), 64'(0));
    chk("t1_ls_gnt_rst", 64'(o_ls_gnt), 64'(0));
    chk("t1_if_rv", 64'(o_if_rvalid), 64'(0));
    chk("t1_ls_rv", 64'(o_ls_rvalid), 64'(0));
    @(posedge clk); #1;
    chk("t1_busy_held", 64'(o_busy), 64'(0));
    i_if_req = 1'b0; i_ls_req = 1'b0;
    @(negedge clk);
    i_rst = 1'b1;

    // Both requesters held continuously: starvation relief and back-to-back grant
    apply_reset();
    grant_log.delete();
    t5_seen   = 1'b0;
    t5_ls_gnt = 1'b0;
    run_cycles(30, 1'b1);
    chk("t4_log_len", 64'(grant_log.size() >= 6), 64'(1));
    for (int i = 0; i < 6; i++) begin
      if (i < grant_log.size()) chk($sformatf("t4_order%0d", i), 64'(grant_log[i]), 64'(exp_order[i]));
    end
    chk("t5_seen", 64'(t5_seen), 64'(1));
    chk("t5_ls_gnt", 64'(t5_ls_gnt), 64'(1));

    // Randomized traffic
    apply_reset();
    run_cycles(600, 1'b0);

    // Stray response while idle
    apply_reset();
    @(posedge clk); #1;
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    i_mem_rvalid = 1'b0;
    @(negedge clk);
    chk("t6_err", 64'(o_err), 64'(1));
    chk("t6_if_rv", 64'(o_if_rvalid), 64'(0));
    chk("t6_ls_rv", 64'(o_ls_rvalid), 64'(0));
    chk("t6_busy", 64'(o_busy), 64'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t6_err_sticky", 64'(o_err), 64'(1));
    i_rst = 1'b0;
    #1;
    chk("t6_err_rst", 64'(o_err), 64'(0));
    @(negedge clk);
    i_rst = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
